// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: multi-cycle add/subtract engine processing one 4-bit
// slice per clock, LSB nibble first, with the carry chained across cycles.
// Valid/ready handshakes on both the operand side and the result side.
module nibble_serial_addsub #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_a,
   input  logic [4*NIBBLES-1:0]   in_b,
   input  logic                   in_m,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   out_s,
   output logic                   out_cout,
   output logic                   out_ovf,
   output logic                   busy
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic            r_m;
   logic            r_carry;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_acc;
   logic [W-1:0]    r_s;
   logic            r_cout;
   logic            r_ovf;

   logic            w_accept;
   logic            w_release;
   logic            w_last;
   logic [3:0]      w_an;
   logic [3:0]      w_bn;
   logic [4:0]      w_sum;
   logic [W+3:0]    w_shift;
   logic [W-1:0]    w_acc_next;

   assign w_accept   = in_valid && in_ready;
   assign w_release  = out_valid && out_ready;
   assign w_last     = (r_cnt == CW'(NIBBLES - 1));

   // Current slice: operands are shifted right each cycle, so slice k is
   // always at bits [3:0].
   assign w_an       = r_a[3:0];
   assign w_bn       = r_b[3:0] ^ {4{r_m}};
   assign w_sum      = {1'b0, w_an} + {1'b0, w_bn} + {4'b0000, r_carry};

   // Partial result enters from the top; after NIBBLES slices slice 0 sits
   // at bits [3:0]. The concatenation form also covers NIBBLES=1.
   assign w_shift    = {w_sum[3:0], r_acc};
   assign w_acc_next = w_shift[W+3:4];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept)  w_state_next = S_RUN;
         S_RUN:   if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (w_release) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_RUN:   busy      = 1'b1;
         S_DONE:  begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b1;
      endcase
   end

   // Operand capture, per-slice arithmetic and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= in_a;
         r_b     <= in_b;
         r_m     <= in_m;
         r_carry <= in_m;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> 4;
         r_b     <= r_b >> 4;
         r_carry <= w_sum[4];
         r_cnt   <= r_cnt + 1'b1;
         r_acc   <= w_acc_next;
         if (w_last) begin
            r_s    <= w_acc_next;
            r_cout <= w_sum[4];
            r_ovf  <= (w_an[3] == w_bn[3]) && (w_sum[3] != w_an[3]);
         end
      end
   end

   assign out_s    = r_s;
   assign out_cout = r_cout;
   assign out_ovf  = r_ovf;

endmodule
